// File: rtl/gt_2bit.sv
// Registered 2-bit unsigned magnitude comparator with a saturating "a > b" event counter.
// Optional build macro GT2_FULL_CMP_EN adds registered aeqb/altb outputs.
module gt_2bit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       a,
    input  logic [1:0]       b,
    input  logic             in_valid,
    output logic             agtb,
    output logic             out_valid,
    output logic [CNT_W-1:0] gt_count
`ifdef GT2_FULL_CMP_EN
    ,
    output logic             aeqb,
    output logic             altb
`endif
);

    // Handshake: a/b are sampled on any rising edge with in_valid=1; there is no ready,
    // so every valid sample yields exactly one out_valid pulse one cycle later.
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             gt;
    logic             agtb_d, agtb_q;
    logic             out_valid_d, out_valid_q;
    logic [CNT_W-1:0] gt_count_d, gt_count_q;

    // Sum-of-products compare, kept explicit so it maps to a handful of LUT inputs.
    always_comb begin
        gt = (a[1] & ~b[1])
           | (a[0] & ~b[1] & ~b[0])
           | (a[1] & a[0] & ~b[0]);
    end

    always_comb begin
        agtb_d      = agtb_q;
        out_valid_d = 1'b0;
        gt_count_d  = gt_count_q;
        if (in_valid) begin
            agtb_d      = gt;
            out_valid_d = 1'b1;
            if (gt && (gt_count_q != CNT_MAX)) begin
                gt_count_d = gt_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            agtb_q      <= 1'b0;
            out_valid_q <= 1'b0;
            gt_count_q  <= '0;
        end else begin
            agtb_q      <= agtb_d;
            out_valid_q <= out_valid_d;
            gt_count_q  <= gt_count_d;
        end
    end

    assign agtb      = agtb_q;
    assign out_valid = out_valid_q;
    assign gt_count  = gt_count_q;

`ifdef GT2_FULL_CMP_EN
    logic eq;
    logic aeqb_d, aeqb_q;
    logic altb_d, altb_q;

    // Less-than falls out of the other two, guaranteeing a one-hot result.
    always_comb begin
        eq     = ~(a[1] ^ b[1]) & ~(a[0] ^ b[0]);
        aeqb_d = aeqb_q;
        altb_d = altb_q;
        if (in_valid) begin
            aeqb_d = eq;
            altb_d = ~gt & ~eq;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aeqb_q <= 1'b0;
            altb_q <= 1'b0;
        end else begin
            aeqb_q <= aeqb_d;
            altb_q <= altb_d;
        end
    end

    assign aeqb = aeqb_q;
    assign altb = altb_q;
`endif

endmodule

// File: tb/tb_gt_2bit.sv
// Self-checking bench for gt_2bit: directed cases plus randomized traffic against a
// behavioural model; a second instance with CNT_W=2 exercises counter saturation.
module tb_gt_2bit;

    localparam int W_MAIN = 8;
    localparam int W_SAT  = 2;
    localparam int MAX_MAIN = (1 << W_MAIN) - 1;
    localparam int MAX_SAT  = (1 << W_SAT) - 1;

    logic              clk;
    logic              reset;
    logic [1:0]        a;
    logic [1:0]        b;
    logic              in_valid;
    logic              agtb, agtb2;
    logic              out_valid, out_valid2;
    logic [W_MAIN-1:0] gt_count;
    logic [W_SAT-1:0]  gt_count2;
`ifdef GT2_FULL_CMP_EN
    logic              aeqb, altb, aeqb2, altb2;
`endif

    int compared;
    int mismatched;

    // Reference model state
    int exp_agtb, exp_ov, exp_cnt_main, exp_cnt_sat, exp_eq, exp_lt;

    gt_2bit #(.CNT_W(W_MAIN)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .in_valid(in_valid),
        .agtb(agtb), .out_valid(out_valid), .gt_count(gt_count)
`ifdef GT2_FULL_CMP_EN
        , .aeqb(aeqb), .altb(altb)
`endif
    );

    gt_2bit #(.CNT_W(W_SAT)) dut_sat (
        .clk(clk), .reset(reset), .a(a), .b(b), .in_valid(in_valid),
        .agtb(agtb2), .out_valid(out_valid2), .gt_count(gt_count2)
`ifdef GT2_FULL_CMP_EN
        , .aeqb(aeqb2), .altb(altb2)
`endif
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic v, input int ta, input int tb_);
        if (r) begin
            exp_agtb = 0; exp_ov = 0; exp_cnt_main = 0; exp_cnt_sat = 0;
            exp_eq = 0; exp_lt = 0;
        end else if (v) begin
            exp_agtb = (ta > tb_) ? 1 : 0;
            exp_eq   = (ta == tb_) ? 1 : 0;
            exp_lt   = (ta < tb_) ? 1 : 0;
            exp_ov   = 1;
            if (ta > tb_) begin
                exp_cnt_main = (exp_cnt_main < MAX_MAIN) ? exp_cnt_main + 1 : MAX_MAIN;
                exp_cnt_sat  = (exp_cnt_sat  < MAX_SAT)  ? exp_cnt_sat + 1  : MAX_SAT;
            end
        end else begin
            exp_ov = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".agtb"},      32'(agtb),      32'(exp_agtb));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
        check({tag, ".gt_count"},  32'(gt_count),  32'(exp_cnt_main));
        check({tag, ".agtb2"},     32'(agtb2),     32'(exp_agtb));
        check({tag, ".gt_count2"}, 32'(gt_count2), 32'(exp_cnt_sat));
`ifdef GT2_FULL_CMP_EN
        check({tag, ".aeqb"},  32'(aeqb),  32'(exp_eq));
        check({tag, ".altb"},  32'(altb),  32'(exp_lt));
        check({tag, ".aeqb2"}, 32'(aeqb2), 32'(exp_eq));
        check({tag, ".altb2"}, 32'(altb2), 32'(exp_lt));
`endif
    endtask

    // Driver: apply inputs at negedge, clock once, update model, check at next negedge.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [1:0] ta, input logic [1:0] tb_);
        reset = r; in_valid = v; a = ta; b = tb_;
        @(posedge clk);
        model_update(r, v, int'(ta), int'(tb_));
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        compared = 0; mismatched = 0;
        exp_agtb = 0; exp_ov = 0; exp_cnt_main = 0; exp_cnt_sat = 0; exp_eq = 0; exp_lt = 0;
        reset = 1'b1; in_valid = 1'b0; a = 2'd0; b = 2'd0;
        @(negedge clk);

        // Reset dominates a valid "greater" sample
        step("rst_hold", 1'b1, 1'b1, 2'd3, 2'd0);
        step("rst_hold", 1'b1, 1'b1, 2'd3, 2'd0);
        check("rst_cnt_zero", 32'(gt_count), 32'd0);

        // Exhaustive sweep, back-to-back
        for (int i = 0; i < 16; i++) begin
            step("sweep", 1'b0, 1'b1, 2'(i / 4), 2'(i % 4));
        end
        check("sweep_cnt6", 32'(gt_count), 32'd6);

        // Hold behaviour: one sample then ignored input changes
        step("hold_rst", 1'b1, 1'b0, 2'd0, 2'd0);
        step("hold_s", 1'b0, 1'b1, 2'd2, 2'd1);
        check("hold_pulse", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step("hold_idle", 1'b0, 1'b0, 2'd0, 2'd3);
        end
        check("hold_agtb", 32'(agtb), 32'd1);
        check("hold_cnt1", 32'(gt_count), 32'd1);

        // Saturation of the narrow counter: 1,2,3,3,3
        step("sat_rst", 1'b1, 1'b0, 2'd0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            step("sat2", 1'b0, 1'b1, 2'd3, 2'd0);
            check("sat2_seq", 32'(gt_count2), 32'((i < 3) ? i + 1 : 3));
        end

        // Mid-stream reset then resume
        step("mid_rst", 1'b1, 1'b1, 2'd3, 2'd0);
        check("mid_rst_cnt", 32'(gt_count), 32'd0);
        step("mid_resume", 1'b0, 1'b1, 2'd3, 2'd1);
        check("mid_resume_cnt", 32'(gt_count), 32'd1);

`ifdef GT2_FULL_CMP_EN
        step("full_eq", 1'b0, 1'b1, 2'd1, 2'd1);
        check("full_eq_flag", 32'(aeqb), 32'd1);
        step("full_lt", 1'b0, 1'b1, 2'd0, 2'd2);
        check("full_lt_flag", 32'(altb), 32'd1);
        step("full_gt", 1'b0, 1'b1, 2'd3, 2'd2);
        check("full_onehot", 32'(agtb) + 32'(aeqb) + 32'(altb), 32'd1);
`endif

        // Randomized traffic with occasional resets and idle cycles
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end

        // Saturation of the wide counter
        step("satw_rst", 1'b1, 1'b0, 2'd0, 2'd0);
        for (int i = 0; i < MAX_MAIN + 5; i++) begin
            step("satw", 1'b0, 1'b1, 2'd2, 2'd1);
        end
        check("satw_max", 32'(gt_count), 32'(MAX_MAIN));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
